// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS multiply/divide with HI/LO registers; optional MULDIV_EARLY_OUT_EN skips CALC for trivial operands
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;
  logic [4:0] cnt;
  logic [1:0] op_r;
  logic sa, sb, sa_in, sb_in, early;
  logic [XLEN-1:0] m, a_mag, b_mag, q, r;
  logic [2*XLEN-1:0] acc, acc_init, acc_step, prod;
  logic [XLEN:0] sum, shl, diff;
  // operand magnitudes and sign flags; only the signed ops (op[0]=0) carry signs
  always_comb begin
    sa_in = ~op[0] & src_a[XLEN-1];
    sb_in = ~op[0] & src_b[XLEN-1];
    a_mag = sa_in ? -src_a : src_a;
    b_mag = sb_in ? -src_b : src_b;
`ifdef MULDIV_EARLY_OUT_EN
    early = op[1] ? (src_b == '0) : (src_a == '0 || src_b == '0);
`else
    early = 1'b0;
`endif
    acc_init = early ? (op[1] ? {a_mag, {XLEN{1'b1}}} : '0) : {{XLEN{1'b0}}, op[1] ? a_mag : b_mag};
  end
  // one iteration: multiply shifts the product right while adding; divide shifts the remainder left and restores on underflow
  always_comb begin
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, acc[0] ? m : {XLEN{1'b0}}};
    shl = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff = shl - {1'b0, m};
    acc_step = op_r[1] ? (diff[XLEN] ? {shl[XLEN-1:0], acc[XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                       : {sum, acc[XLEN-1:1]};
  end
  // sign fix; a zero divisor forces an all-ones quotient while the remainder naturally equals the dividend
  always_comb begin
    prod = (sa ^ sb) ? -acc : acc;
    q = (m == '0) ? {XLEN{1'b1}} : ((sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
    r = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  end
  // next-state logic
  always_comb begin
    state_nx = state;
    busy = state != IDLE;
    state_nx = state == IDLE ? (start ? (early ? FIX : CALC) : IDLE)
             : state == CALC ? (cnt == 5'd31 ? FIX : CALC)
             : IDLE;
  end
  // state, datapath and architectural HI/LO registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
      cnt <= '0;
      op_r <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      m <= '0;
      acc <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_nx;
      done <= state == FIX;
      if (state == IDLE && start) begin
        op_r <= op;
        sa <= sa_in;
        sb <= sb_in;
        m <= op[1] ? b_mag : a_mag;
        acc <= acc_init;
        cnt <= '0;
      end else if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end else if (state == CALC) begin
        acc <= acc_step;
        cnt <= cnt + 5'd1;
      end else begin
        {hi, lo} <= op_r[1] ? {r, q} : prod;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with directed vectors
module tb_muldiv_unit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0] op = '0;
  logic [31:0] src_a = '0, src_b = '0, wdata = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  typedef struct {logic [31:0] hi; logic [31:0] lo; int at;} exp_t;
  exp_t sbq[$];
  exp_t e;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int DZ_LAT = 2;
`else
  localparam int DZ_LAT = 34;
`endif
  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (done) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        chk("result_hi", hi, e.hi);
        chk("result_lo", lo, e.lo);
        chk("done_cycle", cyc, e.at);
      end
    end
  end
  task automatic op_run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int lat);
    @(negedge clk);
    sbq.push_back('{eh, el, cyc + lat});
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; src_a = ~a; src_b = ~b;
    chk("busy_after_e0", busy, 1);
    repeat (lat - 2) @(negedge clk);
    chk("busy_last", busy, 1);
    chk("no_early_done", done, 0);
    @(negedge clk);
    chk("idle_after_done", busy, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hilo", {hi, lo}, 64'h0);
    rst = 1'b0;
    op_run(2'b00, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    op_run(2'b01, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 34);
    op_run(2'b00, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 34);
    op_run(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 34);
    op_run(2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34);
    op_run(2'b11, 32'h7, 32'h2, 32'h1, 32'h3, 34);
    op_run(2'b11, 32'h7, 32'h0, 32'h7, 32'hFFFFFFFF, DZ_LAT);
    hi_we = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_lo_kept", lo, 32'hFFFFFFFF);
    lo_we = 1'b1; wdata = 32'h9ABCDEF0;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo", {hi, lo}, 64'h12345678_9ABCDEF0);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55AA33CC;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi_mtlo_both", {hi, lo}, 64'h55AA33CC_55AA33CC);
    sbq.push_back('{32'h0, 32'd15, cyc + 34});
    start = 1'b1; op = 2'b00; src_a = 32'd3; src_b = 32'd5; hi_we = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; src_a = 32'd7;
    chk("start_beats_mthi", {hi, lo}, 64'h55AA33CC_55AA33CC);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b11; src_b = 32'h0; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk("busy_write_ignored", {hi, lo}, 64'h55AA33CC_55AA33CC);
    repeat (28) @(negedge clk);
    chk("idle_after_ignored", busy, 0);
    @(negedge clk);
    start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_hilo_later", {hi, lo}, 64'h0);
    op_run(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 34);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
